pipelined_control_unit: RTL
===========================

PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 The block SHALL have parameter ALUOP_W, default 2: ALUOp field width, minimum 2; upper bits zero-filled.
REQ-002 The block SHALL have parameter CNT_W, default 16: load-use stall counter width.
REQ-003 The block SHALL have port clk, input, width 1: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-005 The block SHALL have port opcode, input, width 7: ID-stage instruction opcode.
REQ-006 The block SHALL have port id_valid, input, width 1: ID stage holds a real instruction.
REQ-007 The block SHALL have ports id_rs1, id_rs2, id_rd, input, width 5 each: ID-stage register indices.
REQ-008 The block SHALL have port flush, input, width 1: taken branch resolved in MEM; kill younger instructions.
REQ-009 The block SHALL have port stall_out, output, width 1: load-use hazard; hold PC and IF/ID.
REQ-010 The block SHALL have EX-stage outputs ex_valid, ex_alusrc, ex_aluop[ALUOP_W], ex_branch, ex_jump and ex_rd[5].
REQ-011 The block SHALL have MEM-stage outputs mem_valid, mem_memread, mem_memwrite, mem_branch and mem_rd[5].
REQ-012 The block SHALL have WB-stage outputs wb_valid, wb_regwrite, wb_memtoreg and wb_rd[5].
REQ-013 The block SHALL have port illegal, output, width 1: registered flag for an unsupported opcode entering EX.
REQ-014 The block SHALL have port stall_count, output, width CNT_W: saturating count of load-use bubbles.

Function
REQ-015 The decode table SHALL be: R (0110011) -> RegWrite, ALUOp=10.
REQ-016 The decode table SHALL be: ld (0000011) -> MemRead, MemtoReg, ALUSrc, RegWrite, ALUOp=00.
REQ-017 The decode table SHALL be: addi (0010011) -> ALUSrc, RegWrite, ALUOp=00.
REQ-018 The decode table SHALL be: sd (0100011) -> MemWrite, ALUSrc, ALUOp=00.
REQ-019 The decode table SHALL be: branch (1100011) -> Branch, ALUOp=01.
REQ-020 Any control not listed for an opcode SHALL be 0; no X is ever driven.
REQ-021 Any other opcode with id_valid=1 SHALL decode as all-zero controls and SHALL set illegal=1 for one cycle as it enters EX.
REQ-022 Control bits SHALL pass through three register stages, ID/EX, EX/MEM and MEM/WB, with one cycle of latency per stage.
REQ-023 The ex_* outputs SHALL reflect the opcode sampled one cycle earlier.
REQ-024 stall_out SHALL be combinational and SHALL equal id_valid & ex_valid & ex_memread_int & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-025 While stall_out=1, ID/EX SHALL load a bubble: valid=0, all controls 0, rd=0.
REQ-026 While stall_out=1, EX/MEM and MEM/WB SHALL advance normally.
REQ-027 flush=1 SHALL load bubbles into ID/EX and EX/MEM on the same edge; MEM/WB SHALL advance normally.
REQ-028 When flush=1 and stall_out=1 occur together, flush SHALL win and stall_count SHALL NOT increment.
REQ-029 A stage with valid=0 SHALL present all control outputs as 0, regardless of any stored bits.
REQ-030 stall_count SHALL increment by 1 on each cycle where stall_out=1 and flush=0.
REQ-031 stall_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-032 illegal SHALL NOT assert for bubbles, for flushed instructions, or when id_valid=0.

Reset
REQ-033 With reset=1 at a clock edge, all valid bits, controls, rd fields, illegal and stall_count SHALL clear to 0.
REQ-034 Reset SHALL take priority over flush and stall.
REQ-035 A reset asserted mid-pipeline SHALL discard all in-flight instructions.
REQ-036 stall_out SHALL be 0 in the cycle after reset, because ex_valid=0.

Configuration
REQ-037 When CTRL_JAL_EN is defined, opcode 1101111 (jal) SHALL decode to Jump=1, RegWrite=1, ALUOp=00 and all other controls 0, and ex_jump SHALL follow it.
REQ-038 When CTRL_JAL_EN is undefined, opcode 1101111 SHALL be treated as illegal and ex_jump SHALL be tied to 0.

Verification
REQ-039 Reset then feed R, ld, addi, sd, beq on consecutive cycles with id_valid=1 -> ex_aluop = 10, 00, 00, 00, 01 one cycle later; wb_regwrite = 1, 1, 1, 0, 0 three cycles later.
REQ-040 Feed ld x5 then add with rs1=5 -> stall_out=1 for exactly one cycle, a bubble appears in EX, and stall_count=1.
REQ-041 Feed ld x0 then add with rs1=0 -> stall_out=0 and stall_count stays 0.
REQ-042 Feed opcode 1111111 -> illegal=1 for one cycle and all ex_* controls are 0; repeat with CTRL_JAL_EN defined and opcode 1101111 -> ex_jump=1 and illegal=0.
REQ-043 Assert flush while stall_out=1 -> ex_valid=0 and mem_valid=0 next cycle, and stall_count unchanged.
REQ-044 Force stall_count to 16'hFFFF via sustained hazards, then add one more hazard -> stall_count remains 16'hFFFF; assert reset mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// Control unit for a 5-stage pipeline: decodes the ID-stage opcode and carries its control bits through ID/EX, EX/MEM and MEM/WB, with load-use stall detection.
// Optional feature: define CTRL_JAL_EN to decode jal (1101111) as Jump + RegWrite; otherwise jal is illegal and ex_jump stays 0.
module pipelined_control_unit #(
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               id_valid,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic [4:0]         id_rd,
    input  logic               flush,
    output logic               stall_out,
    output logic               ex_valid,
    output logic               ex_alusrc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic [4:0]         ex_rd,
    output logic               mem_valid,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic               mem_branch,
    output logic [4:0]         mem_rd,
    output logic               wb_valid,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic [4:0]         wb_rd,
    output logic               illegal,
    output logic [CNT_W-1:0]   stall_count
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
`ifdef CTRL_JAL_EN
    localparam logic [6:0] OP_JAL  = 7'b1101111;
`endif

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic       jump;
        logic [1:0] aluop;
    } ex_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic branch;
    } mem_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    ex_ctrl_t   dec_ctrl;
    logic       dec_illegal;

    logic       ex_valid_q, ex_valid_d;
    ex_ctrl_t   ex_ctrl_q, ex_ctrl_d;
    logic [4:0] ex_rd_q, ex_rd_d;
    logic       illegal_q, illegal_d;

    logic       mem_valid_q, mem_valid_d;
    mem_ctrl_t  mem_ctrl_q, mem_ctrl_d;
    logic [4:0] mem_rd_q, mem_rd_d;

    logic       wb_valid_q, wb_valid_d;
    wb_ctrl_t   wb_ctrl_q, wb_ctrl_d;
    logic [4:0] wb_rd_q, wb_rd_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        if (id_valid) begin
            case (opcode)
                OP_R:    begin dec_ctrl.regwrite = 1'b1; dec_ctrl.aluop = 2'b10; end
                OP_LD:   begin
                    dec_ctrl.memread  = 1'b1;
                    dec_ctrl.memtoreg = 1'b1;
                    dec_ctrl.alusrc   = 1'b1;
                    dec_ctrl.regwrite = 1'b1;
                end
                OP_ADDI: begin dec_ctrl.alusrc = 1'b1; dec_ctrl.regwrite = 1'b1; end
                OP_SD:   begin dec_ctrl.memwrite = 1'b1; dec_ctrl.alusrc = 1'b1; end
                OP_BR:   begin dec_ctrl.branch = 1'b1; dec_ctrl.aluop = 2'b01; end
`ifdef CTRL_JAL_EN
                OP_JAL:  begin dec_ctrl.jump = 1'b1; dec_ctrl.regwrite = 1'b1; end
`endif
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    assign stall_out = id_valid & ex_valid_q & ex_ctrl_q.memread & (ex_rd_q != 5'd0)
                     & ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));

    always_comb begin
        ex_valid_d  = id_valid;
        ex_ctrl_d   = dec_ctrl;
        ex_rd_d     = id_valid ? id_rd : 5'd0;
        illegal_d   = dec_illegal;
        if (stall_out || flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            ex_rd_d    = 5'd0;
            illegal_d  = 1'b0;
        end

        mem_valid_d = ex_valid_q;
        mem_ctrl_d  = '{regwrite: ex_ctrl_q.regwrite, memread: ex_ctrl_q.memread,
                        memwrite: ex_ctrl_q.memwrite, memtoreg: ex_ctrl_q.memtoreg,
                        branch: ex_ctrl_q.branch};
        mem_rd_d    = ex_rd_q;
        if (flush) begin
            mem_valid_d = 1'b0;
            mem_ctrl_d  = '0;
            mem_rd_d    = 5'd0;
        end

        wb_valid_d = mem_valid_q;
        wb_ctrl_d  = '{regwrite: mem_ctrl_q.regwrite, memtoreg: mem_ctrl_q.memtoreg};
        wb_rd_d    = mem_rd_q;

        cnt_d = cnt_q;
        if (stall_out && !flush && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all stages sample the old values on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_rd_q     <= 5'd0;
            illegal_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_ctrl_q  <= '0;
            mem_rd_q    <= 5'd0;
            wb_valid_q  <= 1'b0;
            wb_ctrl_q   <= '0;
            wb_rd_q     <= 5'd0;
            cnt_q       <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rd_q     <= ex_rd_d;
            illegal_q   <= illegal_d;
            mem_valid_q <= mem_valid_d;
            mem_ctrl_q  <= mem_ctrl_d;
            mem_rd_q    <= mem_rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_rd_q     <= wb_rd_d;
            cnt_q       <= cnt_d;
        end
    end

    // Controls are gated by valid so a bubble never exposes stored bits; jump is only ever set when jal decoding is built in.
    always_comb begin
        ex_aluop = '0;
        if (ex_valid_q) ex_aluop[1:0] = ex_ctrl_q.aluop;
    end

    assign ex_valid     = ex_valid_q;
    assign ex_alusrc    = ex_valid_q & ex_ctrl_q.alusrc;
    assign ex_branch    = ex_valid_q & ex_ctrl_q.branch;
    assign ex_jump      = ex_valid_q & ex_ctrl_q.jump;
    assign ex_rd        = ex_rd_q;
    assign mem_valid    = mem_valid_q;
    assign mem_memread  = mem_valid_q & mem_ctrl_q.memread;
    assign mem_memwrite = mem_valid_q & mem_ctrl_q.memwrite;
    assign mem_branch   = mem_valid_q & mem_ctrl_q.branch;
    assign mem_rd       = mem_rd_q;
    assign wb_valid     = wb_valid_q;
    assign wb_regwrite  = wb_valid_q & wb_ctrl_q.regwrite;
    assign wb_memtoreg  = wb_valid_q & wb_ctrl_q.memtoreg;
    assign wb_rd        = wb_rd_q;
    assign illegal      = illegal_q;
    assign stall_count  = cnt_q;
endmodule
